// File: rtl/nios2os_desc_ram_dp_if.sv
// Avalon-MM bundle for the two descriptor RAM slave ports (s1, s2), plus the
// shared reset_req input and the init_done status output.
interface nios2os_desc_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                      reset_req;
  logic                      init_done;

  logic                      chipselect;
  logic                      read;
  logic                      write;
  logic [ADDR_WIDTH-1:0]     address;
  logic [DATA_WIDTH/8-1:0]   byteenable;
  logic [DATA_WIDTH-1:0]     writedata;
  logic [DATA_WIDTH-1:0]     readdata;
  logic                      readdatavalid;
  logic                      waitrequest;

  logic                      chipselect2;
  logic                      read2;
  logic                      write2;
  logic [ADDR_WIDTH-1:0]     address2;
  logic [DATA_WIDTH/8-1:0]   byteenable2;
  logic [DATA_WIDTH-1:0]     writedata2;
  logic [DATA_WIDTH-1:0]     readdata2;
  logic                      readdatavalid2;
  logic                      waitrequest2;

  modport slave (
    input  reset_req,
    input  chipselect, read, write, address, byteenable, writedata,
    input  chipselect2, read2, write2, address2, byteenable2, writedata2,
    output readdata, readdatavalid, waitrequest,
    output readdata2, readdatavalid2, waitrequest2,
    output init_done
  );

  modport master (
    output reset_req,
    output chipselect, read, write, address, byteenable, writedata,
    output chipselect2, read2, write2, address2, byteenable2, writedata2,
    input  readdata, readdatavalid, waitrequest,
    input  readdata2, readdatavalid2, waitrequest2,
    input  init_done
  );
endinterface

// File: rtl/nios2os_desc_ram_dp.sv
// True dual-port descriptor RAM: pipelined reads, write-first forwarding between
// ports, same-address write arbitration (s1 wins) and an optional clear sweep.
module nios2os_desc_ram_dp #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 7,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic                  clk,
  input logic                  reset,
  nios2os_desc_ram_dp_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [1:0]              wr_req, rd_req, stall, acc_wr, acc_rd;
  logic                    busy, collide;
  logic [ADDR_WIDTH-1:0]   addr  [2];
  logic [DATA_WIDTH-1:0]   wdata [2];
  logic [BE_W-1:0]         be    [2];
  logic [DATA_WIDTH-1:0]   rword [2];

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       lanes
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < BE_W; i++)
      if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
    return r;
  endfunction

  assign addr[0]  = bus.address;
  assign addr[1]  = bus.address2;
  assign wdata[0] = bus.writedata;
  assign wdata[1] = bus.writedata2;
  assign be[0]    = bus.byteenable;
  assign be[1]    = bus.byteenable2;

  // read+write together counts as a write only
  assign wr_req[0] = bus.chipselect  & bus.write;
  assign wr_req[1] = bus.chipselect2 & bus.write2;
  assign rd_req[0] = bus.chipselect  & bus.read  & ~bus.write;
  assign rd_req[1] = bus.chipselect2 & bus.read2 & ~bus.write2;

  assign busy     = reset | bus.reset_req | (state != ST_READY);
  assign collide  = wr_req[0] & wr_req[1] & (addr[0] == addr[1]);
  assign stall[0] = busy;
  assign stall[1] = busy | collide;
  assign acc_wr   = wr_req & ~stall;
  assign acc_rd   = rd_req & ~stall;

  assign bus.waitrequest  = stall[0];
  assign bus.waitrequest2 = stall[1];
  assign bus.init_done    = (state == ST_READY);

  // Write-first: a read sees the other port's same-cycle write, byte-merged
  assign rword[0] = (acc_wr[1] && addr[1] == addr[0]) ?
                    merge_lanes(mem[addr[0]], wdata[1], be[1]) : mem[addr[0]];
  assign rword[1] = (acc_wr[0] && addr[0] == addr[1]) ?
                    merge_lanes(mem[addr[1]], wdata[0], be[0]) : mem[addr[1]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT:  state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_READY;
        end
        default:  state <= ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR && !reset) mem[cnt] <= CLEAR_VALUE;
    if (acc_wr[0]) mem[addr[0]] <= merge_lanes(mem[addr[0]], wdata[0], be[0]);
    if (acc_wr[1]) mem[addr[1]] <= merge_lanes(mem[addr[1]], wdata[1], be[1]);
  end

  // Stage p0: array read captured on the accepting edge; data holds between reads
  logic [1:0]            vld_p0;
  logic [DATA_WIDTH-1:0] data_p0 [2];
  logic [1:0]            vld_out;
  logic [DATA_WIDTH-1:0] data_out [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0     <= '0;
      data_p0[0] <= '0;
      data_p0[1] <= '0;
    end else begin
      vld_p0 <= acc_rd;
      for (int p = 0; p < 2; p++)
        if (acc_rd[p]) data_p0[p] <= rword[p];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Stage p1: extra output register for the two-cycle latency option
      logic [1:0]            vld_p1;
      logic [DATA_WIDTH-1:0] data_p1 [2];

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1     <= '0;
          data_p1[0] <= '0;
          data_p1[1] <= '0;
        end else begin
          vld_p1 <= vld_p0;
          for (int p = 0; p < 2; p++)
            if (vld_p0[p]) data_p1[p] <= data_p0[p];
        end
      end

      assign vld_out     = vld_p1;
      assign data_out[0] = data_p1[0];
      assign data_out[1] = data_p1[1];
    end else begin : g_lat1
      assign vld_out     = vld_p0;
      assign data_out[0] = data_p0[0];
      assign data_out[1] = data_p0[1];
    end
  endgenerate

  assign bus.readdatavalid  = vld_out[0];
  assign bus.readdatavalid2 = vld_out[1];
  assign bus.readdata       = data_out[0];
  assign bus.readdata2      = data_out[1];
endmodule

// File: tb/tb_nios2os_desc_ram_dp.sv
// Directed bench for nios2os_desc_ram_dp: a default instance (latency 1, clear on)
// and a latency-2 instance without the clear sweep.
module tb_nios2os_desc_ram_dp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  int   checks   = 0;
  int   failures = 0;

  nios2os_desc_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus_a ();
  nios2os_desc_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_b ();

  nios2os_desc_ram_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)
  ) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));

  nios2os_desc_ram_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h0)
  ) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_a;
    bus_a.chipselect  = 1'b0; bus_a.read  = 1'b0; bus_a.write  = 1'b0;
    bus_a.chipselect2 = 1'b0; bus_a.read2 = 1'b0; bus_a.write2 = 1'b0;
  endtask

  task automatic idle_b;
    bus_b.chipselect  = 1'b0; bus_b.read  = 1'b0; bus_b.write  = 1'b0;
    bus_b.chipselect2 = 1'b0; bus_b.read2 = 1'b0; bus_b.write2 = 1'b0;
  endtask

  task automatic a1_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] lanes);
    bus_a.chipselect = 1'b1; bus_a.write = 1'b1; bus_a.read = 1'b0;
    bus_a.address = a; bus_a.writedata = d; bus_a.byteenable = lanes;
    tick();
    idle_a();
  endtask

  task automatic a1_read(input logic [6:0] a, output logic [31:0] d, output logic v);
    bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.write = 1'b0; bus_a.address = a;
    tick();
    v = bus_a.readdatavalid;
    d = bus_a.readdata;
    idle_a();
  endtask

  task automatic a2_read(input logic [6:0] a, output logic [31:0] d, output logic v);
    bus_a.chipselect2 = 1'b1; bus_a.read2 = 1'b1; bus_a.write2 = 1'b0; bus_a.address2 = a;
    tick();
    v = bus_a.readdatavalid2;
    d = bus_a.readdata2;
    idle_a();
  endtask

  task automatic b1_write(input logic [3:0] a, input logic [31:0] d);
    bus_b.chipselect = 1'b1; bus_b.write = 1'b1; bus_b.read = 1'b0;
    bus_b.address = a; bus_b.writedata = d; bus_b.byteenable = 4'hF;
    tick();
    idle_b();
  endtask

  task automatic wait_init_a(output int n, output int bad);
    n = 0; bad = 0;
    while (!bus_a.init_done && n < 400) begin
      if (!(bus_a.waitrequest && bus_a.waitrequest2)) bad++;
      tick();
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          n, bad, vmiss;

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.reset_req = 1'b0; bus_b.reset_req = 1'b0;
    bus_a.address = '0; bus_a.address2 = '0; bus_a.writedata = '0; bus_a.writedata2 = '0;
    bus_a.byteenable = 4'hF; bus_a.byteenable2 = 4'hF;
    bus_b.address = '0; bus_b.address2 = '0; bus_b.writedata = '0; bus_b.writedata2 = '0;
    bus_b.byteenable = 4'hF; bus_b.byteenable2 = 4'hF;
    idle_a(); idle_b();
    repeat (3) tick();

    chk("rst_rdv",   32'(bus_a.readdatavalid),  32'd0);
    chk("rst_rdv2",  32'(bus_a.readdatavalid2), 32'd0);
    chk("rst_init",  32'(bus_a.init_done),      32'd0);
    chk("rst_wr",    32'(bus_a.waitrequest),    32'd1);
    chk("rst_wr2",   32'(bus_a.waitrequest2),   32'd1);
    chk("rst_rd",    bus_a.readdata,            32'd0);
    chk("rst_rd2",   bus_a.readdata2,           32'd0);

    // Sweep of 128 words plus the INIT cycle
    reset_a = 1'b0;
    wait_init_a(n, bad);
    chk("init_lat",  32'(n),   32'd129);
    chk("init_wait", 32'(bad), 32'd0);

    vmiss = 0;
    for (int i = 0; i < 128; i++) begin
      a2_read(7'(i), d, v);
      if (!v) vmiss++;
      chk("clr_rd2", d, 32'd0);
    end
    chk("clr_vld2", 32'(vmiss), 32'd0);

    // Reset mid-sweep restarts the clear from word 0
    a1_write(7'd100, 32'hDEADBEEF, 4'hF);
    a1_read(7'd100, d, v);
    chk("pre_rb100", d, 32'hDEADBEEF);
    chk("pre_vld",   32'(v), 32'd1);
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    repeat (50) tick();
    reset_a = 1'b1; tick();
    chk("rst_mid_wr", 32'(bus_a.waitrequest), 32'd1);
    reset_a = 1'b0;
    wait_init_a(n, bad);
    chk("restart_lat",  32'(n),   32'd129);
    chk("restart_wait", 32'(bad), 32'd0);
    a1_read(7'd100, d, v);
    chk("post_rb100", d, 32'd0);

    // Same-address write collision: s1 wins, s2 lands one cycle later
    bus_a.chipselect  = 1'b1; bus_a.write  = 1'b1; bus_a.address  = 7'd5;
    bus_a.writedata   = 32'h11111111; bus_a.byteenable  = 4'hF;
    bus_a.chipselect2 = 1'b1; bus_a.write2 = 1'b1; bus_a.address2 = 7'd5;
    bus_a.writedata2  = 32'h22222222; bus_a.byteenable2 = 4'hF;
    #1;
    chk("coll_wr",  32'(bus_a.waitrequest),  32'd0);
    chk("coll_wr2", 32'(bus_a.waitrequest2), 32'd1);
    tick();
    bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
    #1;
    chk("coll_wr2_next", 32'(bus_a.waitrequest2), 32'd0);
    tick();
    idle_a();
    a1_read(7'd5, d, v);
    chk("coll_rb5", d, 32'h22222222);

    // Forwarding s1 write -> s2 read, with byte lanes
    a1_write(7'd9, 32'hAABBCCDD, 4'hF);
    bus_a.chipselect  = 1'b1; bus_a.write = 1'b1; bus_a.address = 7'd9;
    bus_a.writedata   = 32'h00001234; bus_a.byteenable = 4'b0011;
    bus_a.chipselect2 = 1'b1; bus_a.read2 = 1'b1; bus_a.address2 = 7'd9;
    tick();
    chk("fwd_vld2", 32'(bus_a.readdatavalid2), 32'd1);
    chk("fwd_rd2",  bus_a.readdata2, 32'hAABB1234);
    idle_a();
    a1_read(7'd9, d, v);
    chk("fwd_rb9", d, 32'hAABB1234);

    // Forwarding s2 write -> s1 read
    bus_a.chipselect2 = 1'b1; bus_a.write2 = 1'b1; bus_a.address2 = 7'd9;
    bus_a.writedata2  = 32'h99000000; bus_a.byteenable2 = 4'b1000;
    bus_a.chipselect  = 1'b1; bus_a.read = 1'b1; bus_a.address = 7'd9;
    tick();
    chk("fwd_rd1", bus_a.readdata, 32'h99BB1234);
    idle_a();
    bus_a.byteenable2 = 4'hF;

    a1_write(7'd9, 32'hFFFFFFFF, 4'b0000);
    a2_read(7'd9, d, v);
    chk("be0_rb9", d, 32'h99BB1234);

    // read+write together is a write with no readdatavalid
    bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.write = 1'b1;
    bus_a.address = 7'd20; bus_a.writedata = 32'h00000055; bus_a.byteenable = 4'hF;
    tick();
    chk("rw_novld", 32'(bus_a.readdatavalid), 32'd0);
    idle_a();
    a1_read(7'd20, d, v);
    chk("rw_rb20", d, 32'h00000055);
    tick();
    chk("hold_vld", 32'(bus_a.readdatavalid), 32'd0);
    chk("hold_rd",  bus_a.readdata, 32'h00000055);

    // reset_req: delivered read completes, new write is stalled and dropped
    bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.address = 7'd5;
    tick();
    bus_a.reset_req = 1'b1;
    bus_a.read = 1'b0; bus_a.write = 1'b1; bus_a.address = 7'd6; bus_a.writedata = 32'h77;
    #1;
    chk("rr_wr",  32'(bus_a.waitrequest),   32'd1);
    chk("rr_wr2", 32'(bus_a.waitrequest2),  32'd1);
    chk("rr_vld", 32'(bus_a.readdatavalid), 32'd1);
    chk("rr_rd",  bus_a.readdata, 32'h22222222);
    tick();
    idle_a();
    bus_a.reset_req = 1'b0;
    a1_read(7'd6, d, v);
    chk("rr_rb6", d, 32'd0);

    // Latency-2 instance, no clear sweep
    chk("b_rst_wr",   32'(bus_b.waitrequest), 32'd1);
    chk("b_rst_init", 32'(bus_b.init_done),   32'd0);
    reset_b = 1'b0;
    tick();
    chk("b_init", 32'(bus_b.init_done), 32'd1);
    for (int i = 0; i < 4; i++) b1_write(4'(i), 32'(i));

    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus_b.chipselect = 1'b1; bus_b.read = 1'b1; bus_b.address = 4'(i);
      end else begin
        idle_b();
      end
      tick();
      v = (i >= 1 && i <= 4);
      chk("l2_vld", 32'(bus_b.readdatavalid), 32'(v));
      if (v) chk("l2_data", bus_b.readdata, 32'(i - 1));
    end
    chk("l2_hold", bus_b.readdata, 32'd3);

    // Outstanding latency-2 read survives reset_req
    bus_b.chipselect = 1'b1; bus_b.read = 1'b1; bus_b.address = 4'd2;
    tick();
    bus_b.reset_req = 1'b1;
    bus_b.read = 1'b0; bus_b.write = 1'b1; bus_b.address = 4'd3; bus_b.writedata = 32'h99;
    #1;
    chk("b_rr_wr",  32'(bus_b.waitrequest),   32'd1);
    chk("b_rr_vld0", 32'(bus_b.readdatavalid), 32'd0);
    tick();
    chk("b_rr_vld1", 32'(bus_b.readdatavalid), 32'd1);
    chk("b_rr_rd",   bus_b.readdata, 32'd2);
    idle_b();
    bus_b.reset_req = 1'b0;
    bus_b.chipselect = 1'b1; bus_b.read = 1'b1; bus_b.address = 4'd3;
    tick();
    idle_b();
    tick();
    chk("b_rr_vld3", 32'(bus_b.readdatavalid), 32'd1);
    chk("b_rr_rb3",  bus_b.readdata, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
